// File: rtl/output_stage_sequencer_pkg.sv
// Shared types, saturation bounds and the clamp helper for the
// requantization output stage sequencer.
package output_stage_pkg;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Working width for the clamp helper; wide enough for any accumulator
    // width the sequencer is expected to carry.
    localparam int SAT_W = 64;

    // Largest value representable in a signed p-bit word.
    function automatic logic signed [SAT_W-1:0] SAT_MAX(input int p);
        return (64'sd1 <<< (p - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed p-bit word.
    function automatic logic signed [SAT_W-1:0] SAT_MIN(input int p);
        return -(64'sd1 <<< (p - 1));
    endfunction

    // Clamp a sign-extended value into the signed p-bit range. In-range
    // values pass unchanged so the caller's truncation keeps the low bits.
    function automatic logic signed [SAT_W-1:0] sat_to_precision(
        input logic signed [SAT_W-1:0] x,
        input int                      p
    );
        logic signed [SAT_W-1:0] r;
        if (x > SAT_MAX(p)) begin
            r = SAT_MAX(p);
        end else if (x < SAT_MIN(p)) begin
            r = SAT_MIN(p);
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/output_stage_sequencer_if.sv
// Bundles the input vector handshake, bias memory port, output stage
// operand bus and output vector handshake of the sequencer.
interface output_stage_sequencer_if #(
    parameter int NUM_NEURONS    = 10,
    parameter int PRECISION      = 8,
    parameter int BIAS_PRECISION = 32,
    parameter int IDX_W          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
);
    // input vector handshake
    logic                                  in_valid;
    logic                                  in_ready;
    logic [NUM_NEURONS*BIAS_PRECISION-1:0] in_acc;
    logic [BIAS_PRECISION-1:0]             in_ai;
    // bias memory read port (one cycle latency)
    logic [IDX_W-1:0]                      bias_addr;
    logic [BIAS_PRECISION-1:0]             bias_data;
    // output stage operand bus
    logic                                  os_ce;
    logic [BIAS_PRECISION-1:0]             os_acc;
    logic [BIAS_PRECISION-1:0]             os_ai;
    logic [BIAS_PRECISION-1:0]             os_bias;
    logic [BIAS_PRECISION-1:0]             os_long_out;
    // output vector handshake
    logic                                  out_valid;
    logic                                  out_ready;
    logic [NUM_NEURONS*PRECISION-1:0]      out_data;
    logic                                  busy;

    // The sequencer itself.
    modport master (
        input  in_valid, in_acc, in_ai, bias_data, os_long_out, out_ready,
        output in_ready, bias_addr, os_ce, os_acc, os_ai, os_bias,
               out_valid, out_data, busy
    );

    // Producer, bias memory, output stage and consumer around it.
    modport slave (
        output in_valid, in_acc, in_ai, bias_data, os_long_out, out_ready,
        input  in_ready, bias_addr, os_ce, os_acc, os_ai, os_bias,
               out_valid, out_data, busy
    );

endinterface

// File: rtl/output_stage_sequencer_requant_sat.sv
// Combinational signed clamp of an output stage long result down to the
// layer's output element width.
module requant_sat
    import output_stage_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  long_i,
    output logic [OUT_W-1:0] sat_o
);

    logic signed [SAT_W-1:0] ext_s;
    logic signed [SAT_W-1:0] clamp_s;

    // Sign-extend, clamp to the OUT_W signed range, keep the low bits.
    always_comb begin
        ext_s   = SAT_W'(signed'(long_i));
        clamp_s = sat_to_precision(ext_s, OUT_W);
        sat_o   = OUT_W'(clamp_s);
    end

endmodule

// File: rtl/output_stage_sequencer.sv
// Walks one layer vector through the requantization output stage: issue a
// bias read (A), drive the stage operands (B), capture the saturated stage
// result (C), one neuron per cycle, then hold the packed vector until the
// next layer takes it.
module output_stage_sequencer
    import output_stage_pkg::*;
#(
    parameter int NUM_NEURONS    = 10,
    parameter int PRECISION      = 8,
    parameter int BIAS_PRECISION = 32,
    parameter int IDX_W          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    output_stage_sequencer_if.master  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // control state
    seq_state_t                            state_q, state_d;
    logic                                  in_ready_q, in_ready_d;
    logic                                  busy_q, busy_d;
    logic                                  out_valid_q, out_valid_d;

    // latched vector
    logic [NUM_NEURONS*BIAS_PRECISION-1:0] acc_q, acc_d;
    logic [BIAS_PRECISION-1:0]             ai_q, ai_d;

    // pipeline indices and stage valid bits (os_ce_q is the B-stage valid)
    logic [IDX_W-1:0]                      issue_idx_q, issue_idx_d;
    logic [IDX_W-1:0]                      cap_idx_q, cap_idx_d;
    logic                                  a_vld_q, a_vld_d;
    logic                                  os_ce_q, os_ce_d;
    logic                                  c_vld_q, c_vld_d;

    // output stage operands and result buffer
    logic [BIAS_PRECISION-1:0]             os_acc_q, os_acc_d;
    logic [BIAS_PRECISION-1:0]             os_ai_q, os_ai_d;
    logic [NUM_NEURONS*PRECISION-1:0]      out_data_q, out_data_d;

    // strobes
    logic                                  accept_s;
    logic                                  capture_s;
    logic                                  last_cap_s;
    logic [BIAS_PRECISION-1:0]             acc_sel_s;
    logic [PRECISION-1:0]                  sat_s;

    // Stage C clamp of the registered output stage result.
    requant_sat #(
        .IN_W  (BIAS_PRECISION),
        .OUT_W (PRECISION)
    ) u_requant_sat (
        .long_i (bus.os_long_out),
        .sat_o  (sat_s)
    );

    // Next-state logic: accept in IDLE, finish RUN on the last capture,
    // leave DONE only on an output transfer.
    always_comb begin
        state_d    = state_q;
        accept_s   = 1'b0;
        capture_s  = 1'b0;
        last_cap_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    accept_s = 1'b1;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                capture_s = c_vld_q;
                if (c_vld_q && (cap_idx_q == LAST_IDX)) begin
                    last_cap_s = 1'b1;
                    state_d    = DONE;
                end else begin
                    state_d    = RUN;
                end
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they line up
    // with the state register.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DONE);
    end

    // Vector latch and stage A issue index.
    always_comb begin
        acc_d       = acc_q;
        ai_d        = ai_q;
        issue_idx_d = issue_idx_q;
        a_vld_d     = a_vld_q;
        if (accept_s) begin
            acc_d       = bus.in_acc;
            ai_d        = bus.in_ai;
            issue_idx_d = IDX_ZERO;
            a_vld_d     = 1'b1;
        end else if ((state_q == RUN) && a_vld_q) begin
            if (issue_idx_q == LAST_IDX) begin
                a_vld_d = 1'b0;
            end else begin
                issue_idx_d = issue_idx_q + IDX_ONE;
            end
        end else begin
            a_vld_d = a_vld_q;
        end
    end

    // Stage B operands: the accumulator of the neuron issued last cycle;
    // operands hold their previous values while the stage is disabled.
    always_comb begin
        acc_sel_s = acc_q[int'(issue_idx_q)*BIAS_PRECISION +: BIAS_PRECISION];
        os_ce_d   = a_vld_q && (state_q == RUN);
        c_vld_d   = os_ce_q && (state_q == RUN);
        if (os_ce_d) begin
            os_acc_d = acc_sel_s;
            os_ai_d  = ai_q;
        end else begin
            os_acc_d = os_acc_q;
            os_ai_d  = os_ai_q;
        end
    end

    // Stage C capture into the packed output buffer.
    always_comb begin
        out_data_d = out_data_q;
        cap_idx_d  = cap_idx_q;
        if (accept_s) begin
            cap_idx_d = IDX_ZERO;
        end else if (capture_s) begin
            out_data_d[int'(cap_idx_q)*PRECISION +: PRECISION] = sat_s;
            if (last_cap_s) begin
                cap_idx_d = cap_idx_q;
            end else begin
                cap_idx_d = cap_idx_q + IDX_ONE;
            end
        end else begin
            cap_idx_d = cap_idx_q;
        end
    end

    // Control state and handshake flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Datapath registers; a reset discards any partial vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            ai_q        <= '0;
            issue_idx_q <= IDX_ZERO;
            cap_idx_q   <= IDX_ZERO;
            a_vld_q     <= 1'b0;
            os_ce_q     <= 1'b0;
            c_vld_q     <= 1'b0;
            os_acc_q    <= '0;
            os_ai_q     <= '0;
            out_data_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            ai_q        <= ai_d;
            issue_idx_q <= issue_idx_d;
            cap_idx_q   <= cap_idx_d;
            a_vld_q     <= a_vld_d;
            os_ce_q     <= os_ce_d;
            c_vld_q     <= c_vld_d;
            os_acc_q    <= os_acc_d;
            os_ai_q     <= os_ai_d;
            out_data_q  <= out_data_d;
        end
    end

    // The bias address is the stage A index; bias data is forwarded
    // straight through because the memory already registered it.
    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.bias_addr = issue_idx_q;
    assign bus.os_ce     = os_ce_q;
    assign bus.os_acc    = os_acc_q;
    assign bus.os_ai     = os_ai_q;
    assign bus.os_bias   = bus.bias_data;

endmodule

// File: tb/tb_output_stage_sequencer.sv
// Directed bench: a 4-neuron and a 1-neuron sequencer, each with a
// one-cycle bias memory and an output stage model
// (long = ((acc - 5*ai) * 2^30) >>> 32 + bias).
module tb_output_stage_sequencer;

    localparam logic [127:0] V1_ACC = {32'd0, 32'd1000, 32'd200, 32'd600};
    localparam logic [31:0]  V1_AI  = 32'd40;
    localparam logic [31:0]  V1_OUT = 32'h807F0069;
    localparam logic [127:0] VB_ACC = {32'd9, 32'd4, 32'hFFFFFFD8, 32'd100};
    localparam logic [31:0]  VB_AI  = 32'd4;
    localparam logic [31:0]  VB_OUT = 32'h80FCF119;
    localparam logic [127:0] V2_ACC = {32'd260, 32'd100, 32'd1200, 32'hFFFFFE70};
    localparam logic [31:0]  V2_AI  = 32'hFFFFFFF8;
    localparam logic [31:0]  V2_OUT = 32'h4F267FA7;
    localparam logic [127:0] JUNK   = {4{32'h00001000}};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    output_stage_sequencer_if #(.NUM_NEURONS(4), .PRECISION(8), .BIAS_PRECISION(32)) bus4 ();
    output_stage_sequencer_if #(.NUM_NEURONS(1), .PRECISION(8), .BIAS_PRECISION(32)) bus1 ();

    output_stage_sequencer #(.NUM_NEURONS(4), .PRECISION(8), .BIAS_PRECISION(32)) dut4 (
        .clk (clk), .rst (rst), .bus (bus4.master)
    );
    output_stage_sequencer #(.NUM_NEURONS(1), .PRECISION(8), .BIAS_PRECISION(32)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1.master)
    );

    logic [31:0] bmem4 [4];
    logic [31:0] bmem1;

    function automatic logic [31:0] os_model(input logic [31:0] acc, input logic [31:0] ai,
                                             input logic [31:0] bias);
        logic signed [95:0] d;
        logic signed [95:0] p;
        logic signed [95:0] r;
        d = 96'(signed'(acc)) - 96'sd5 * 96'(signed'(ai));
        p = d * 96'sd1073741824;
        r = (p >>> 32) + 96'(signed'(bias));
        return 32'(r);
    endfunction

    // bias memories with one-cycle read latency
    always @(posedge clk) begin
        bus4.bias_data <= bmem4[bus4.bias_addr];
        bus1.bias_data <= bmem1;
    end

    // registered output stage models
    always @(posedge clk) begin
        if (bus4.os_ce) bus4.os_long_out <= os_model(bus4.os_acc, bus4.os_ai, bus4.os_bias);
        if (bus1.os_ce) bus1.os_long_out <= os_model(bus1.os_acc, bus1.os_ai, bus1.os_bias);
    end

    int tests = 0;
    int fails = 0;

    // observations from the 4-neuron run helper
    int          ov_cyc;
    int          ce_cnt;
    int          ce_cyc [8];
    logic [31:0] ce_acc [8];
    logic [31:0] ce_ai  [8];
    logic [1:0]  addr_log [8];

    task automatic start4(input logic [127:0] acc, input logic [31:0] ai);
        @(negedge clk);
        bus4.in_acc   = acc;
        bus4.in_ai    = ai;
        bus4.in_valid = 1'b1;
    endtask

    // Follows a run from the accept edge (cycle c = c-th negedge after it)
    // until out_valid is seen; perturb toggles in_valid/in_acc/out_ready.
    task automatic observe4(input bit perturb);
        ov_cyc = -1;
        ce_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (perturb) begin
                bus4.in_valid  = (c % 2 == 1);
                bus4.in_acc    = JUNK;
                bus4.in_ai     = 32'd999;
                bus4.out_ready = (c >= 2 && c <= 5);
            end else begin
                bus4.in_valid = 1'b0;
            end
            if (c <= 8) addr_log[c-1] = bus4.bias_addr;
            if (bus4.os_ce && ce_cnt < 8) begin
                ce_cyc[ce_cnt] = c;
                ce_acc[ce_cnt] = bus4.os_acc;
                ce_ai[ce_cnt]  = bus4.os_ai;
                ce_cnt++;
            end
            if (bus4.out_valid) begin
                ov_cyc = c;
                break;
            end
        end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_acc = '0; bus4.in_ai = '0; bus4.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_acc = '0; bus1.in_ai = '0; bus1.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (bus4.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", bus4.in_ready); end
        tests++; if (bus4.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus4.out_valid); end
        tests++; if (bus4.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus4.busy); end
        tests++; if (bus4.os_ce !== 1'b0) begin fails++; $display("FAIL reset_os_ce: got %b want 0", bus4.os_ce); end
        tests++; if (bus4.bias_addr !== 2'd0) begin fails++; $display("FAIL reset_bias_addr: got %0d want 0", bus4.bias_addr); end
        tests++; if (bus4.os_acc !== 32'd0 || bus4.os_ai !== 32'd0) begin fails++; $display("FAIL reset_os_ops: got %h/%h want 0/0", bus4.os_acc, bus4.os_ai); end
        tests++; if (bus4.out_data !== 32'd0) begin fails++; $display("FAIL reset_out_data: got %h want 0", bus4.out_data); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (bus4.in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b want 1", bus4.in_ready); end
        tests++; if (bus1.in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready_n1: got %b want 1", bus1.in_ready); end
    endtask

    task automatic test_single_vector();
        bmem4[0] = 32'd5; bmem4[1] = 32'd0; bmem4[2] = 32'd0; bmem4[3] = 32'hFFFFFDA8;
        start4(V1_ACC, V1_AI);
        observe4(1'b0);
        tests++; if (ov_cyc !== 7) begin fails++; $display("FAIL single_ov_cycle: got %0d want 7", ov_cyc); end
        tests++; if (bus4.out_data !== V1_OUT) begin fails++; $display("FAIL single_out_data: got %h want %h", bus4.out_data, V1_OUT); end
        tests++; if (ce_cnt !== 4) begin fails++; $display("FAIL single_ce_count: got %0d want 4", ce_cnt); end
        tests++; if (ce_cyc[0] !== 2 || ce_cyc[3] !== 5) begin fails++; $display("FAIL single_ce_window: got %0d..%0d want 2..5", ce_cyc[0], ce_cyc[3]); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (addr_log[k] !== 2'(k)) begin fails++; $display("FAIL single_bias_addr: cycle %0d got %0d want %0d", k + 1, addr_log[k], k); end
            tests++;
            if (ce_acc[k] !== V1_ACC[k*32 +: 32] || ce_ai[k] !== V1_AI) begin
                fails++; $display("FAIL single_os_ops: neuron %0d got %h/%h want %h/%h", k, ce_acc[k], ce_ai[k], V1_ACC[k*32 +: 32], V1_AI);
            end
        end
        tests++; if (bus4.in_ready !== 1'b0 || bus4.busy !== 1'b1) begin fails++; $display("FAIL single_done_flags: got ready=%b busy=%b want 0/1", bus4.in_ready, bus4.busy); end
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
        tests++; if (bus4.out_valid !== 1'b0 || bus4.busy !== 1'b0 || bus4.in_ready !== 1'b1) begin
            fails++; $display("FAIL single_after_xfer: got valid=%b busy=%b ready=%b want 0/0/1", bus4.out_valid, bus4.busy, bus4.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int ov1, ov2, ir1;
        logic [31:0] d1, d2;
        ov1 = -1; ov2 = -1; ir1 = -1; d1 = '0; d2 = '0;
        @(negedge clk);
        bus4.in_acc = V1_ACC; bus4.in_ai = V1_AI; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin bus4.in_acc = VB_ACC; bus4.in_ai = VB_AI; end
            if (ov1 >= 0 && ir1 < 0 && bus4.in_ready) ir1 = c;
            if (bus4.out_valid && ov1 < 0) begin
                ov1 = c; d1 = bus4.out_data;
            end else if (bus4.out_valid) begin
                ov2 = c; d2 = bus4.out_data;
                bus4.in_valid = 1'b0;
                break;
            end
        end
        bus4.in_valid = 1'b0;
        @(negedge clk);
        bus4.out_ready = 1'b0;
        tests++; if (ov1 !== 7) begin fails++; $display("FAIL b2b_first_ov: got %0d want 7", ov1); end
        tests++; if (d1 !== V1_OUT) begin fails++; $display("FAIL b2b_first_data: got %h want %h", d1, V1_OUT); end
        tests++; if (ir1 !== 8) begin fails++; $display("FAIL b2b_ready_rise: got %0d want 8", ir1); end
        tests++; if (ov2 !== 15) begin fails++; $display("FAIL b2b_second_ov: got %0d want 15", ov2); end
        tests++; if (d2 !== VB_OUT) begin fails++; $display("FAIL b2b_second_data: got %h want %h", d2, VB_OUT); end
    endtask

    task automatic test_reset_mid_run();
        start4(V1_ACC, V1_AI);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus4.in_valid = 1'b0;
        end
        tests++; if (bus4.os_ce !== 1'b1) begin fails++; $display("FAIL midrun_ce_before: got %b want 1", bus4.os_ce); end
        rst = 1'b1;
        #1;
        tests++; if (bus4.os_ce !== 1'b0) begin fails++; $display("FAIL midrun_ce_async: got %b want 0", bus4.os_ce); end
        tests++; if (bus4.busy !== 1'b0 || bus4.in_ready !== 1'b0 || bus4.out_valid !== 1'b0) begin
            fails++; $display("FAIL midrun_flags: got busy=%b ready=%b valid=%b want 0/0/0", bus4.busy, bus4.in_ready, bus4.out_valid);
        end
        tests++; if (bus4.bias_addr !== 2'd0 || bus4.os_acc !== 32'd0 || bus4.os_ai !== 32'd0 || bus4.out_data !== 32'd0) begin
            fails++; $display("FAIL midrun_data: got addr=%0d acc=%h ai=%h out=%h want zeros", bus4.bias_addr, bus4.os_acc, bus4.os_ai, bus4.out_data);
        end
        @(posedge clk);
        #1;
        tests++; if (bus4.busy !== 1'b0 || bus4.os_ce !== 1'b0) begin fails++; $display("FAIL midrun_held: got busy=%b ce=%b want 0/0", bus4.busy, bus4.os_ce); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start4(V1_ACC, V1_AI);
        observe4(1'b0);
        tests++; if (ov_cyc !== 7) begin fails++; $display("FAIL midrun_rerun_ov: got %0d want 7", ov_cyc); end
        tests++; if (bus4.out_data !== V1_OUT) begin fails++; $display("FAIL midrun_rerun_data: got %h want %h", bus4.out_data, V1_OUT); end
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
    endtask

    task automatic test_ignored_inputs();
        bmem4[0] = 32'd1; bmem4[1] = 32'd2; bmem4[2] = 32'd3; bmem4[3] = 32'd4;
        start4(V2_ACC, V2_AI);
        observe4(1'b1);
        tests++; if (ov_cyc !== 7) begin fails++; $display("FAIL ignore_ov_cycle: got %0d want 7", ov_cyc); end
        tests++; if (ce_cnt !== 4) begin fails++; $display("FAIL ignore_ce_count: got %0d want 4", ce_cnt); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (ce_acc[k] !== V2_ACC[k*32 +: 32] || ce_ai[k] !== V2_AI) begin
                fails++; $display("FAIL ignore_os_ops: neuron %0d got %h/%h want %h/%h", k, ce_acc[k], ce_ai[k], V2_ACC[k*32 +: 32], V2_AI);
            end
        end
        tests++; if (bus4.out_data !== V2_OUT) begin fails++; $display("FAIL ignore_out_data: got %h want %h", bus4.out_data, V2_OUT); end
        @(negedge clk);
        tests++; if (bus4.out_valid !== 1'b1) begin fails++; $display("FAIL ignore_valid_held: got %b want 1", bus4.out_valid); end
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
    endtask

    task automatic test_stalled_consumer();
        int bad;
        bad = 0;
        start4(V2_ACC, V2_AI);
        observe4(1'b0);
        tests++; if (ov_cyc !== 7) begin fails++; $display("FAIL stall_ov_cycle: got %0d want 7", ov_cyc); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus4.out_data !== V2_OUT || bus4.out_valid !== 1'b1 || bus4.in_ready !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
        tests++; if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1 || bus4.busy !== 1'b0) begin
            fails++; $display("FAIL stall_xfer: got valid=%b ready=%b busy=%b want 0/1/0", bus4.out_valid, bus4.in_ready, bus4.busy);
        end
        @(negedge clk);
        tests++; if (bus4.out_valid !== 1'b0 || bus4.busy !== 1'b0) begin fails++; $display("FAIL stall_idle: got valid=%b busy=%b want 0/0", bus4.out_valid, bus4.busy); end
    endtask

    task automatic test_n1();
        int ov, cnt;
        logic [31:0] acc_seen;
        ov = -1; cnt = 0; acc_seen = '0;
        bmem1 = 32'd3;
        @(negedge clk);
        bus1.in_acc = 32'd500; bus1.in_ai = 32'd0; bus1.in_valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus1.in_valid = 1'b0;
            if (bus1.os_ce) begin cnt++; acc_seen = bus1.os_acc; end
            if (bus1.out_valid) begin ov = c; break; end
        end
        tests++; if (ov !== 4) begin fails++; $display("FAIL n1_ov_cycle: got %0d want 4", ov); end
        tests++; if (cnt !== 1) begin fails++; $display("FAIL n1_ce_count: got %0d want 1", cnt); end
        tests++; if (acc_seen !== 32'd500) begin fails++; $display("FAIL n1_os_acc: got %0d want 500", acc_seen); end
        tests++; if (bus1.out_data !== 8'h7F) begin fails++; $display("FAIL n1_out_data: got %h want 7f", bus1.out_data); end
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        tests++; if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) begin fails++; $display("FAIL n1_xfer: got valid=%b ready=%b want 0/1", bus1.out_valid, bus1.in_ready); end
    endtask

    initial begin
        test_reset();
        test_single_vector();
        test_back_to_back();
        test_reset_mid_run();
        test_ignored_inputs();
        test_stalled_consumer();
        test_n1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
